// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD mm:ss countdown timer.
package timer_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned ALARM_CNT_W = 8;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;
    localparam bcd_digit_t SEC_T_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } timer_state_t;

    typedef struct packed {
        bcd_digit_t min_t;
        bcd_digit_t min_u;
        bcd_digit_t sec_t;
        bcd_digit_t sec_u;
    } mmss_t;

    // Saturate an out-of-range load digit to the largest legal value.
    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input bcd_digit_t max_v);
        return (d > max_v) ? max_v : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps to WRAP and borrows from the next digit at zero.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter bcd_digit_t WRAP = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       is_zero,
    output logic       borrow_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (borrow_in) begin
            digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
        end
    end

    assign is_zero    = (digit == 4'd0);
    assign borrow_out = borrow_in && is_zero;

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with pause/resume, done pulse and timed alarm.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned ALARM_S = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       load,
    input  logic [3:0] ld_min_t,
    input  logic [3:0] ld_min_u,
    input  logic [3:0] ld_sec_t,
    input  logic [3:0] ld_sec_u,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [ALARM_CNT_W-1:0] ALARM_LOAD = ALARM_CNT_W'(ALARM_S);
    localparam logic [ALARM_CNT_W-1:0] ALARM_ONE  = ALARM_CNT_W'(1);

    timer_state_t           state;
    timer_state_t           state_nx;
    logic [ALARM_CNT_W-1:0] alarm_cnt;

    mmss_t ld_clamped;
    mmss_t digit_ld_val;
    logic  digit_ld;

    logic load_acc;
    logic dec_en;
    logic expire;
    logic alarm_dec;
    logic alarm_ack;

    logic [3:0] zero;
    logic       borrow_sec_t;
    logic       borrow_min_u;
    logic       borrow_min_t;
    logic       unused_borrow_top;
    logic       count_zero;
    logic       count_one;

    assign ld_clamped.min_t = clamp_digit(ld_min_t, DIGIT_MAX);
    assign ld_clamped.min_u = clamp_digit(ld_min_u, DIGIT_MAX);
    assign ld_clamped.sec_t = clamp_digit(ld_sec_t, SEC_T_MAX);
    assign ld_clamped.sec_u = clamp_digit(ld_sec_u, DIGIT_MAX);

    // clear reuses the digit load path with an all-zero value
    assign digit_ld     = clear || load_acc;
    assign digit_ld_val = clear ? '0 : ld_clamped;

    assign count_zero = &zero;
    assign count_one  = zero[3] && zero[2] && zero[1] && (sec_u == 4'd1);

    bcd_down_digit #(.WRAP(DIGIT_MAX)) u_sec_u (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (digit_ld),
        .load_val   (digit_ld_val.sec_u),
        .borrow_in  (dec_en),
        .digit      (sec_u),
        .is_zero    (zero[0]),
        .borrow_out (borrow_sec_t)
    );

    bcd_down_digit #(.WRAP(SEC_T_MAX)) u_sec_t (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (digit_ld),
        .load_val   (digit_ld_val.sec_t),
        .borrow_in  (borrow_sec_t),
        .digit      (sec_t),
        .is_zero    (zero[1]),
        .borrow_out (borrow_min_u)
    );

    bcd_down_digit #(.WRAP(DIGIT_MAX)) u_min_u (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (digit_ld),
        .load_val   (digit_ld_val.min_u),
        .borrow_in  (borrow_min_u),
        .digit      (min_u),
        .is_zero    (zero[2]),
        .borrow_out (borrow_min_t)
    );

    // min_t cannot be borrowed out of: 00:00 is terminal
    bcd_down_digit #(.WRAP(DIGIT_MAX)) u_min_t (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (digit_ld),
        .load_val   (digit_ld_val.min_t),
        .borrow_in  (borrow_min_t),
        .digit      (min_t),
        .is_zero    (zero[3]),
        .borrow_out (unused_borrow_top)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Strict priority: only the highest asserted command is considered.
    always_comb begin
        state_nx  = state;
        load_acc  = 1'b0;
        dec_en    = 1'b0;
        expire    = 1'b0;
        alarm_dec = 1'b0;
        alarm_ack = 1'b0;
        if (clear) begin
            state_nx = IDLE;
        end else if (load) begin
            load_acc = (state == IDLE) || (state == PAUSE);
        end else if (start) begin
            if (((state == IDLE) || (state == PAUSE)) && !count_zero) begin
                state_nx = RUN;
            end
        end else if (stop) begin
            if (state == RUN) begin
                state_nx = PAUSE;
            end else if (state == ALARM) begin
                state_nx  = IDLE;
                alarm_ack = 1'b1;
            end
        end else if (tick_1s) begin
            if (state == RUN) begin
                dec_en = 1'b1;
                if (count_one) begin
                    expire   = 1'b1;
                    state_nx = ALARM;
                end
            end else if (state == ALARM) begin
                alarm_dec = 1'b1;
                if (alarm_cnt <= ALARM_ONE) begin
                    state_nx = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt <= '0;
        end else if (clear || alarm_ack) begin
            alarm_cnt <= '0;
        end else if (expire) begin
            alarm_cnt <= ALARM_LOAD;
        end else if (alarm_dec) begin
            alarm_cnt <= alarm_cnt - ALARM_ONE;
        end
    end

    // Status flags follow the next state so they switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            alarm   <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= (state_nx == RUN);
            alarm   <= (state_nx == ALARM);
            done    <= expire;
        end
    end

endmodule
